pipeline_hazard_ctrl: RTL and testbench

Parametrised hazard and stall controller for the in-order pipeline, sitting between ID/EX decode and the PC, IF/ID and ID/EX latches. Detects load-use hazards across a configurable number of source operands and holds the pipeline for a configurable load latency. Converts a taken branch into a flush window of configurable length and freezes everything while data memory is busy. Keeps saturating event counters for load stalls and branch flushes.

---
 rtl/hazard_pkg.sv | 27 ++
 rtl/hazard_sat_counter.sv | 36 +++
 rtl/pipeline_hazard_ctrl.sv | 172 +++++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types and defaults for the pipeline hazard controller.
//   hz_state_t      : controller states (idle, load-use stall, branch flush)
//   DEF_REG_ADDR_W  : default register index width
//   DEF_CNT_W       : default event counter width
//   max_int()       : elaboration-time helper for sizing the window counter
package hazard_pkg;

  typedef enum logic [1:0] {
    HZ_IDLE       = 2'd0,
    HZ_LOAD_STALL = 2'd1,
    HZ_FLUSH      = 2'd2
  } hz_state_t;

  localparam int DEF_REG_ADDR_W = 5;
  localparam int DEF_CNT_W      = 16;

  function automatic int max_int(input int a, input int b);
    int r;
    if (a > b) begin
      r = a;
    end else begin
      r = b;
    end
    return r;
  endfunction

endpackage

// File: rtl/hazard_sat_counter.sv
// hazard_sat_counter: event counter that sticks at all-ones instead of wrapping.
// Ports:
//   clk_i   in   clock
//   rst_i   in   synchronous active-high reset, clears the count
//   inc_i   in   count one event this cycle
//   hold_i  in   freeze the count regardless of inc_i
//   cnt_o   out  current count (W bits)
module hazard_sat_counter #(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         inc_i,
  input  logic         hold_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] r_cnt;
  logic         w_sat;

  assign w_sat = (r_cnt == {W{1'b1}});

  // Count register: clear on reset, step on an unheld event until saturated.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_cnt <= '0;
    end else if (inc_i && !hold_i && !w_sat) begin
      r_cnt <= r_cnt + W'(1);
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign cnt_o = r_cnt;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: load-use hazard / branch flush / memory freeze controller
// for the in-order pipeline. Control outputs are combinational from state and
// inputs; state, window counter and event counters update on the rising edge.
// Optional build macro: HAZ_X0_EXEMPT_EN -- when defined, a load targeting x0
// never raises a hazard (x0 is hardwired to zero).
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   branch_taken_i          ID resolved a taken branch
//   ex_mem_read_i, ex_rd_i  EX instruction is a load / its destination
//   id_rs_i, id_rs_used_i   ID source indices (packed) and their valid bits
//   mem_busy_i              data memory busy: freeze everything
//   pc_write_o, ifid_write_o, ifid_flush_o, idex_bubble_o  pipeline controls
//   load_stall_cnt_o, flush_cnt_o                         saturating event counts
module pipeline_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W     = DEF_REG_ADDR_W,
  parameter int NUM_SRC        = 2,
  parameter int LOAD_LAT       = 1,
  parameter int BRANCH_PENALTY = 1,
  parameter int CNT_W          = DEF_CNT_W
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          branch_taken_i,
  input  logic                          ex_mem_read_i,
  input  logic [REG_ADDR_W-1:0]         ex_rd_i,
  input  logic [NUM_SRC*REG_ADDR_W-1:0] id_rs_i,
  input  logic [NUM_SRC-1:0]            id_rs_used_i,
  input  logic                          mem_busy_i,
  output logic                          pc_write_o,
  output logic                          ifid_write_o,
  output logic                          ifid_flush_o,
  output logic                          idex_bubble_o,
  output logic [CNT_W-1:0]              load_stall_cnt_o,
  output logic [CNT_W-1:0]              flush_cnt_o
);

  localparam int MAX_WIN = max_int(LOAD_LAT, BRANCH_PENALTY);
  localparam int REM_W   = $clog2(MAX_WIN) + 1;

  hz_state_t        r_state;
  hz_state_t        w_state_nxt;
  logic [REM_W-1:0] r_rem;
  logic [REM_W-1:0] w_rem_nxt;
  logic             w_src_match;
  logic             w_hazard;
  logic             w_ld_inc;
  logic             w_fl_inc;

  // Load-use hazard: EX load whose destination equals any valid ID source.
  always_comb begin
    w_src_match = 1'b0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (id_rs_used_i[k] && (id_rs_i[k*REG_ADDR_W +: REG_ADDR_W] == ex_rd_i)) begin
        w_src_match = 1'b1;
      end else begin
        w_src_match = w_src_match;
      end
    end
`ifdef HAZ_X0_EXEMPT_EN
    if (ex_rd_i == '0) begin
      w_hazard = 1'b0;
    end else begin
      w_hazard = ex_mem_read_i && w_src_match;
    end
`else
    w_hazard = ex_mem_read_i && w_src_match;
`endif
  end

  // Next state and control outputs; freeze outranks everything, and while in
  // a window the EX/branch inputs are not looked at.
  always_comb begin
    pc_write_o    = 1'b1;
    ifid_write_o  = 1'b1;
    ifid_flush_o  = 1'b0;
    idex_bubble_o = 1'b0;
    w_state_nxt   = r_state;
    w_rem_nxt     = r_rem;
    w_ld_inc      = 1'b0;
    w_fl_inc      = 1'b0;
    if (rst_i) begin
      w_state_nxt = HZ_IDLE;
      w_rem_nxt   = '0;
    end else if (mem_busy_i) begin
      pc_write_o   = 1'b0;
      ifid_write_o = 1'b0;
    end else begin
      case (r_state)
        HZ_IDLE: begin
          if (w_hazard) begin
            pc_write_o    = 1'b0;
            ifid_write_o  = 1'b0;
            idex_bubble_o = 1'b1;
            w_ld_inc      = 1'b1;
            if (LOAD_LAT > 1) begin
              w_state_nxt = HZ_LOAD_STALL;
              w_rem_nxt   = REM_W'(LOAD_LAT - 1);
            end else begin
              w_state_nxt = HZ_IDLE;
            end
          end else if (branch_taken_i) begin
            ifid_flush_o = 1'b1;
            w_fl_inc     = 1'b1;
            if (BRANCH_PENALTY > 1) begin
              w_state_nxt = HZ_FLUSH;
              w_rem_nxt   = REM_W'(BRANCH_PENALTY - 1);
            end else begin
              w_state_nxt = HZ_IDLE;
            end
          end else begin
            w_state_nxt = HZ_IDLE;
          end
        end
        HZ_LOAD_STALL: begin
          pc_write_o    = 1'b0;
          ifid_write_o  = 1'b0;
          idex_bubble_o = 1'b1;
          w_rem_nxt     = r_rem - REM_W'(1);
          if (r_rem == REM_W'(1)) begin
            w_state_nxt = HZ_IDLE;
          end else begin
            w_state_nxt = HZ_LOAD_STALL;
          end
        end
        HZ_FLUSH: begin
          pc_write_o   = 1'b0;
          ifid_flush_o = 1'b1;
          w_rem_nxt    = r_rem - REM_W'(1);
          if (r_rem == REM_W'(1)) begin
            w_state_nxt = HZ_IDLE;
          end else begin
            w_state_nxt = HZ_FLUSH;
          end
        end
        default: begin
          w_state_nxt = HZ_IDLE;
          w_rem_nxt   = '0;
        end
      endcase
    end
  end

  // State and remaining-window register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= HZ_IDLE;
      r_rem   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_rem   <= w_rem_nxt;
    end
  end

  hazard_sat_counter #(.W(CNT_W)) u_load_cnt (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .inc_i  (w_ld_inc),
    .hold_i (mem_busy_i),
    .cnt_o  (load_stall_cnt_o)
  );

  hazard_sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .inc_i  (w_fl_inc),
    .hold_i (mem_busy_i),
    .cnt_o  (flush_cnt_o)
  );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl. Two instances share one stimulus stream:
//   A: LOAD_LAT=1, BRANCH_PENALTY=2, CNT_W=2
//   B: LOAD_LAT=3, BRANCH_PENALTY=1, CNT_W=16
// Directed rows carry hand-computed control nibbles {pc,ifid_w,flush,bubble};
// a window-countdown model checks outputs and counters on every cycle.
module tb_pipeline_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst, br, mr, busy;
  logic [4:0] rd;
  logic [9:0] rs;
  logic [1:0] used;

  logic       pc_a, ifw_a, fl_a, bb_a;
  logic [1:0] lc_a, fc_a;
  logic       pc_b, ifw_b, fl_b, bb_b;
  logic [15:0] lc_b, fc_b;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.REG_ADDR_W(5), .NUM_SRC(2), .LOAD_LAT(1),
                         .BRANCH_PENALTY(2), .CNT_W(2)) dut_a (
    .clk_i(clk), .rst_i(rst), .branch_taken_i(br), .ex_mem_read_i(mr),
    .ex_rd_i(rd), .id_rs_i(rs), .id_rs_used_i(used), .mem_busy_i(busy),
    .pc_write_o(pc_a), .ifid_write_o(ifw_a), .ifid_flush_o(fl_a),
    .idex_bubble_o(bb_a), .load_stall_cnt_o(lc_a), .flush_cnt_o(fc_a));

  pipeline_hazard_ctrl #(.REG_ADDR_W(5), .NUM_SRC(2), .LOAD_LAT(3),
                         .BRANCH_PENALTY(1), .CNT_W(16)) dut_b (
    .clk_i(clk), .rst_i(rst), .branch_taken_i(br), .ex_mem_read_i(mr),
    .ex_rd_i(rd), .id_rs_i(rs), .id_rs_used_i(used), .mem_busy_i(busy),
    .pc_write_o(pc_b), .ifid_write_o(ifw_b), .ifid_flush_o(fl_b),
    .idex_bubble_o(bb_b), .load_stall_cnt_o(lc_b), .flush_cnt_o(fc_b));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int  s_left[2] = '{0, 0};
  int  f_left[2] = '{0, 0};
  int  ld_c[2]   = '{0, 0};
  int  fl_c[2]   = '{0, 0};
  int  ll_m[2]   = '{1, 3};
  int  bp_m[2]   = '{2, 1};
  int  cmax[2]   = '{3, 65535};
  bit  mvalid    = 1'b0;

  function automatic bit model_haz();
    bit m;
    m = (used[0] && rs[4:0] == rd) || (used[1] && rs[9:5] == rd);
`ifdef HAZ_X0_EXEMPT_EN
    if (rd == 5'd0) m = 1'b0;
`endif
    return mr && m;
  endfunction

  always @(negedge clk) begin
    logic [3:0]  e;
    logic [3:0]  got;
    logic [31:0] dl, df;
    bit          haz;
    haz = model_haz();
    for (int i = 0; i < 2; i++) begin
      got = (i == 0) ? {pc_a, ifw_a, fl_a, bb_a} : {pc_b, ifw_b, fl_b, bb_b};
      dl  = (i == 0) ? 32'(lc_a) : 32'(lc_b);
      df  = (i == 0) ? 32'(fc_a) : 32'(fc_b);
      if (mvalid) begin
        chk((i == 0) ? "A.model.ld_cnt" : "B.model.ld_cnt", dl, 32'(ld_c[i]));
        chk((i == 0) ? "A.model.fl_cnt" : "B.model.fl_cnt", df, 32'(fl_c[i]));
      end
      if (rst) begin
        e = 4'b1100; s_left[i] = 0; f_left[i] = 0; ld_c[i] = 0; fl_c[i] = 0;
      end else if (busy) begin
        e = 4'b0000;
      end else if (s_left[i] > 0) begin
        e = 4'b0001; s_left[i]--;
      end else if (f_left[i] > 0) begin
        e = 4'b0110; f_left[i]--;
      end else if (haz) begin
        e = 4'b0001; s_left[i] = ll_m[i] - 1;
        if (ld_c[i] < cmax[i]) ld_c[i]++;
      end else if (br) begin
        e = 4'b1110; f_left[i] = bp_m[i] - 1;
        if (fl_c[i] < cmax[i]) fl_c[i]++;
      end else begin
        e = 4'b1100;
      end
      if (mvalid || rst) chk((i == 0) ? "A.model.out" : "B.model.out", 32'(got), 32'(e));
    end
    if (rst) mvalid = 1'b1;
  end

  // ---------------- directed vectors ----------------
  typedef struct packed {
    logic       rst, br, mr;
    logic [4:0] rd, rs0, rs1;
    logic [1:0] used;
    logic       busy;
    logic [3:0] ea, eb;
  } vec_t;

  vec_t tbl[$];

`ifdef HAZ_X0_EXEMPT_EN
  localparam logic [3:0] X0_EXP = 4'b1100;
`else
  localparam logic [3:0] X0_EXP = 4'b0001;
`endif

  task automatic add(input logic r, input logic b, input logic m, input logic [4:0] d,
                     input logic [4:0] s0, input logic [4:0] s1, input logic [1:0] u,
                     input logic bz, input logic [3:0] ea, input logic [3:0] eb);
    vec_t v;
    v.rst = r; v.br = b; v.mr = m; v.rd = d; v.rs0 = s0; v.rs1 = s1;
    v.used = u; v.busy = bz; v.ea = ea; v.eb = eb;
    tbl.push_back(v);
  endtask

  initial begin
    //   rst br mr rd     rs0    rs1    used   busy  A        B
    add(1, 0, 0, 5'd0, 5'd0, 5'd0, 2'b00, 0, 4'b1100, 4'b1100); // 0 reset
    add(1, 0, 1, 5'd5, 5'd5, 5'd0, 2'b01, 0, 4'b1100, 4'b1100); // 1 reset forces defaults
    add(0, 0, 1, 5'd5, 5'd3, 5'd5, 2'b11, 0, 4'b0001, 4'b0001); // 2 hazard
    add(0, 0, 0, 5'd0, 5'd0, 5'd0, 2'b00, 1, 4'b0000, 4'b0000); // 3 freeze
    add(0, 0, 0, 5'd0, 5'd0, 5'd0, 2'b00, 0, 4'b1100, 4'b0001); // 4
    add(0, 0, 0, 5'd0, 5'd0, 5'd0, 2'b00, 0, 4'b1100, 4'b0001); // 5 B window ends
    add(0, 1, 0, 5'd0, 5'd0, 5'd0, 2'b00, 0, 4'b1110, 4'b1110); // 6 branch
    add(0, 0, 0, 5'd0, 5'd0, 5'd0, 2'b00, 0, 4'b0110, 4'b1100); // 7 A flush window
    add(0, 1, 1, 5'd7, 5'd7, 5'd0, 2'b01, 0, 4'b0001, 4'b0001); // 8 hazard+branch
    add(0, 0, 0, 5'd0, 5'd0, 5'd0, 2'b00, 0, 4'b1100, 4'b0001); // 9
    add(0, 0, 0, 5'd0, 5'd0, 5'd0, 2'b00, 0, 4'b1100, 4'b0001); // 10
    add(0, 0, 1, 5'd0, 5'd0, 5'd0, 2'b01, 0, X0_EXP,  X0_EXP);  // 11 x0 load
    add(0, 0, 0, 5'd0, 5'd0, 5'd0, 2'b00, 0, 4'b1100, X0_EXP);  // 12
    add(0, 0, 0, 5'd0, 5'd0, 5'd0, 2'b00, 0, 4'b1100, X0_EXP);  // 13
    add(0, 0, 1, 5'd5, 5'd5, 5'd9, 2'b10, 0, 4'b1100, 4'b1100); // 14 match but unused
    add(0, 0, 0, 5'd5, 5'd5, 5'd0, 2'b01, 0, 4'b1100, 4'b1100); // 15 match, not a load
    for (int k = 16; k <= 20; k++)                              // 16-20 back-to-back
      add(0, 0, 1, 5'd4, 5'd4, 5'd0, 2'b01, 0, 4'b0001, 4'b0001);
    add(1, 0, 1, 5'd4, 5'd4, 5'd0, 2'b01, 0, 4'b1100, 4'b1100); // 21 reset mid-window
    add(0, 0, 1, 5'd4, 5'd4, 5'd0, 2'b01, 0, 4'b0001, 4'b0001); // 22 first cycle after reset
    add(0, 0, 0, 5'd0, 5'd0, 5'd0, 2'b00, 0, 4'b1100, 4'b0001); // 23
    add(0, 0, 0, 5'd0, 5'd0, 5'd0, 2'b00, 0, 4'b1100, 4'b0001); // 24
    add(0, 0, 0, 5'd0, 5'd0, 5'd0, 2'b00, 0, 4'b1100, 4'b1100); // 25
    add(0, 1, 0, 5'd0, 5'd0, 5'd0, 2'b00, 0, 4'b1110, 4'b1110); // 26 branch
    add(0, 0, 0, 5'd0, 5'd0, 5'd0, 2'b00, 1, 4'b0000, 4'b0000); // 27 freeze in flush
    add(0, 0, 0, 5'd0, 5'd0, 5'd0, 2'b00, 0, 4'b0110, 4'b1100); // 28
    add(0, 0, 0, 5'd0, 5'd0, 5'd0, 2'b00, 0, 4'b1100, 4'b1100); // 29
    add(0, 0, 1, 5'd6, 5'd6, 5'd0, 2'b01, 1, 4'b0000, 4'b0000); // 30 freeze beats hazard
    add(0, 0, 0, 5'd0, 5'd0, 5'd0, 2'b00, 0, 4'b1100, 4'b1100); // 31

    for (int i = 0; i < tbl.size(); i++) begin
      rst  = tbl[i].rst;  br = tbl[i].br;  mr = tbl[i].mr;  rd = tbl[i].rd;
      rs   = {tbl[i].rs1, tbl[i].rs0};
      used = tbl[i].used; busy = tbl[i].busy;
      @(negedge clk);
      #1;
      chk($sformatf("A.row%0d", i), 32'({pc_a, ifw_a, fl_a, bb_a}), 32'(tbl[i].ea));
      chk($sformatf("B.row%0d", i), 32'({pc_b, ifw_b, fl_b, bb_b}), 32'(tbl[i].eb));
      if (i == 3)  chk("B.ld_cnt.after_detect", 32'(lc_b), 32'd1);
      if (i == 8)  chk("A.fl_cnt.after_branch", 32'(fc_a), 32'd1);
      if (i == 9)  chk("A.fl_cnt.hazard_wins", 32'(fc_a), 32'd1);
      if (i == 21) chk("A.ld_cnt.saturated", 32'(lc_a), 32'd3);
      if (i == 22) begin
        chk("A.ld_cnt.reset", 32'(lc_a), 32'd0);
        chk("B.ld_cnt.reset", 32'(lc_b), 32'd0);
        chk("A.fl_cnt.reset", 32'(fc_a), 32'd0);
        chk("B.fl_cnt.reset", 32'(fc_b), 32'd0);
      end
      if (i == 31) begin
        chk("A.ld_cnt.final", 32'(lc_a), 32'd1);
        chk("B.ld_cnt.final", 32'(lc_b), 32'd1);
        chk("A.fl_cnt.final", 32'(fc_a), 32'd1);
        chk("B.fl_cnt.final", 32'(fc_b), 32'd1);
        chk("model.A.ld_final", 32'(ld_c[0]), 32'd1);
        chk("model.B.fl_final", 32'(fl_c[1]), 32'd1);
      end
      @(posedge clk);
      #1;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
